instr_fetch_queue: RTL and testbench

//   Fetch-side reader of the program counter.
//   - Owns the fetch PC and issues word reads to instruction memory over a req/ack handshake.
//   - Buffers returned instructions, each tagged with its PC, in a small FIFO for the decode stage.
//   - Flushes and restarts on a redirect (taken branch or jump) from the PC/branch logic.

---
 rtl/instr_fetch_queue_if.sv | 27 ++
 rtl/instr_fetch_queue.sv | 116 +++++++++++
 tb/tb_instr_fetch_queue.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_queue_if.sv
// Fetch-side bundle: redirect from branch logic, instruction-memory read port, decode-side queue head.
// master modport is the fetch queue; slave modport is the memory/decode/branch environment.
interface instr_fetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;

    modport master (
        input  redirect, redirect_pc, mem_ack, mem_rdata, instr_ready,
        output mem_req, mem_addr, instr_valid, instr, instr_pc
    );

    modport slave (
        output redirect, redirect_pc, mem_ack, mem_rdata, instr_ready,
        input  mem_req, mem_addr, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch PC owner: one outstanding word read at a time, PC-tagged results queued for decode.
// Head entry is registered; a redirect flushes the queue and drains any in-flight read.
module instr_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    instr_fetch_queue_if.master     bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DATA_W-1:0]  instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic [DATA_W-1:0]  mem_ins [DEPTH];
    logic [ADDR_W-1:0]  mem_pc  [DEPTH];
    logic               push, pop, space;
    logic               unused_redirect_lsb;

    assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

    always_comb begin
        pop        = (count_q != '0) && bus.instr_ready && !bus.redirect;
        push       = (state_q == WAIT) && bus.mem_ack && !bus.redirect;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        head_d     = head_q + PTR_W'(pop);
        tail_d     = tail_q + PTR_W'(push);
        space      = count_d < CNT_W'(DEPTH);
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;

        case (state_q)
            IDLE: begin
                if (!bus.redirect && space) begin
                    state_d = WAIT;
                    addr_d  = fetch_pc_q;
                end
            end
            WAIT: begin
                if (bus.redirect) begin
                    // address must not move while the old read is still in flight
                    state_d = bus.mem_ack ? IDLE : DISCARD;
                end else if (bus.mem_ack) begin
                    fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                    if (space) addr_d  = fetch_pc_q + ADDR_W'(4);
                    else       state_d = IDLE;
                end
            end
            DISCARD: begin
                if (bus.mem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bus.redirect) begin
            fetch_pc_d = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end

        // an entry pushed into the slot that becomes head must bypass the array
        if (push && (tail_q == head_d)) begin
            instr_d    = bus.mem_rdata;
            instr_pc_d = fetch_pc_q;
        end else begin
            instr_d    = mem_ins[head_d];
            instr_pc_d = mem_pc[head_d];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= '0;
            addr_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_ins[tail_q] <= bus.mem_rdata;
            mem_pc[tail_q]  <= fetch_pc_q;
        end
    end

    assign bus.mem_req     = (state_q != IDLE);
    assign bus.mem_addr    = addr_q;
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: reset, streaming, backpressure/wrap, redirects, reset mid-request.
module tb_instr_fetch_queue;
    localparam logic [31:0] K = 32'hA5A5A5A5;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] nxt_addr;

    instr_fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    instr_fetch_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // memory answers only while a request is up, with data derived from the address
    task automatic cycle(input logic ack, input logic rdy);
        bus.mem_ack     = ack & bus.mem_req;
        bus.mem_rdata   = bus.mem_addr ^ K;
        bus.instr_ready = rdy;
        if (bus.mem_ack) nxt_addr += 32'd4;
        tick();
    endtask

    initial begin
        int acc;
        int pops;
        logic [31:0] exp_pc;
        logic [31:0] old_addr;

        reset           = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = '0;
        bus.instr_ready = 1'b0;
        nxt_addr        = '0;

        // reset state
        tick(); tick();
        check("rst_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("rst_instr", bus.instr, 32'd0);
        check("rst_pc", bus.instr_pc, 32'd0);
        reset = 1'b0;
        tick();
        check("rel_req", {31'd0, bus.mem_req}, 32'd1);
        check("rel_addr", bus.mem_addr, 32'd0);

        // back-to-back stream, one instruction per cycle
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1);
            check("strm_valid", {31'd0, bus.instr_valid}, 32'd1);
            check("strm_pc", bus.instr_pc, 32'(4 * i));
            check("strm_instr", bus.instr, 32'(4 * i) ^ K);
        end

        // backpressure: empty the queue, then fill it with decode stalled
        cycle(1'b0, 1'b1);
        check("bp_empty", {31'd0, bus.instr_valid}, 32'd0);
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.mem_req) acc++;
            cycle(1'b1, 1'b0);
        end
        check("bp_acks", 32'(acc), 32'd4);
        check("bp_req_drop", {31'd0, bus.mem_req}, 32'd0);
        check("bp_head", bus.instr_pc, 32'h20);
        cycle(1'b0, 1'b1);
        check("bp_reissue", {31'd0, bus.mem_req}, 32'd1);
        check("bp_addr", bus.mem_addr, 32'h30);
        check("bp_head2", bus.instr_pc, 32'h24);
        cycle(1'b1, 1'b0);
        check("bp_full_again", {31'd0, bus.mem_req}, 32'd0);

        // pointer wrap under irregular ack/ready patterns
        exp_pc = 32'h24;
        pops   = 0;
        for (int c = 0; c < 300 && pops < 12; c++) begin
            logic a, r;
            a = (c % 3) != 1;
            r = (c % 2) == 0;
            if (bus.instr_valid && r) begin
                check("wrap_pc", bus.instr_pc, exp_pc);
                check("wrap_instr", bus.instr, exp_pc ^ K);
                exp_pc += 32'd4;
                pops++;
            end
            cycle(a, r);
        end
        check("wrap_pops", 32'(pops), 32'd12);

        // redirect while a read is outstanding and the ack is late
        repeat (6) cycle(1'b0, 1'b1);
        check("rw_empty", {31'd0, bus.instr_valid}, 32'd0);
        check("rw_req", {31'd0, bus.mem_req}, 32'd1);
        check("rw_addr", bus.mem_addr, nxt_addr);
        old_addr        = nxt_addr;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h00400023;
        cycle(1'b0, 1'b0);
        bus.redirect    = 1'b0;
        check("rw_hold_req", {31'd0, bus.mem_req}, 32'd1);
        check("rw_hold_addr", bus.mem_addr, old_addr);
        check("rw_hold_empty", {31'd0, bus.instr_valid}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0);
            check("rw_held_addr", bus.mem_addr, old_addr);
        end
        cycle(1'b1, 1'b0);
        check("rw_dropped", {31'd0, bus.instr_valid}, 32'd0);
        check("rw_idle", {31'd0, bus.mem_req}, 32'd0);
        cycle(1'b0, 1'b0);
        check("rw_new_req", {31'd0, bus.mem_req}, 32'd1);
        check("rw_new_addr", bus.mem_addr, 32'h00400020);
        check("rw_still_empty", {31'd0, bus.instr_valid}, 32'd0);

        // redirect, ack and pop all in one cycle
        cycle(1'b1, 1'b0);
        check("rap_pre_valid", {31'd0, bus.instr_valid}, 32'd1);
        check("rap_pre_pc", bus.instr_pc, 32'h00400020);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h00001000;
        cycle(1'b1, 1'b1);
        bus.redirect    = 1'b0;
        check("rap_flush", {31'd0, bus.instr_valid}, 32'd0);
        check("rap_idle", {31'd0, bus.mem_req}, 32'd0);
        cycle(1'b0, 1'b1);
        check("rap_no_glitch", {31'd0, bus.instr_valid}, 32'd0);
        check("rap_req", {31'd0, bus.mem_req}, 32'd1);
        check("rap_addr", bus.mem_addr, 32'h00001000);
        cycle(1'b1, 1'b1);
        check("rap_valid", {31'd0, bus.instr_valid}, 32'd1);
        check("rap_pc", bus.instr_pc, 32'h00001000);
        check("rap_instr", bus.instr, 32'h00001000 ^ K);

        // reset in the middle of a request; a stale ack must not land
        check("mr_pre_req", {31'd0, bus.mem_req}, 32'd1);
        reset           = 1'b1;
        bus.mem_ack     = 1'b0;
        bus.instr_ready = 1'b0;
        tick();
        check("mr_req", {31'd0, bus.mem_req}, 32'd0);
        check("mr_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("mr_instr", bus.instr, 32'd0);
        check("mr_pc", bus.instr_pc, 32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEADBEEF;
        tick();
        reset = 1'b0;
        tick();
        check("mr_rel_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("mr_rel_req", {31'd0, bus.mem_req}, 32'd1);
        check("mr_rel_addr", bus.mem_addr, 32'd0);
        bus.mem_ack = 1'b0;
        tick();
        check("mr_stale_ack", {31'd0, bus.instr_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
